// File: rtl/tlb_search_responder.sv
// TLB entry array with a registered search responder, TLBWI/TLBWR write port and invalidate-all walker.
// Latency: a search response is valid exactly one cycle after the request is accepted.
// Backpressure: a stalled response holds; new requests wait while the response is stalled or the walker is busy.
module tlb_search_responder #(
   parameter int TLBNUM = 16,
   parameter int IDX_WD = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              s_req_valid,
   output logic              s_req_ready,
   input  logic [18:0]       s_vpn2,
   input  logic              s_odd_page,
   input  logic [7:0]        s_asid,
   output logic              s_resp_valid,
   input  logic              s_resp_ready,
   output logic              s_found,
   output logic [IDX_WD-1:0] s_index,
   output logic [19:0]       s_pfn,
   output logic [2:0]        s_c,
   output logic              s_d,
   output logic              s_v,
   input  logic              we,
   input  logic [IDX_WD-1:0] w_index,
   input  logic [18:0]       w_vpn2,
   input  logic [7:0]        w_asid,
   input  logic              w_g,
   input  logic [19:0]       w_pfn0,
   input  logic [2:0]        w_c0,
   input  logic              w_d0,
   input  logic              w_v0,
   input  logic [19:0]       w_pfn1,
   input  logic [2:0]        w_c1,
   input  logic              w_d1,
   input  logic              w_v1,
   input  logic              inv_all,
   output logic              busy
);

   typedef struct packed {
      logic [19:0] pfn;
      logic [2:0]  c;
      logic        d;
   } page_t;

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      page_t       p0;
      page_t       p1;
   } tlb_entry_t;

   typedef struct packed {
      logic              found;
      logic [IDX_WD-1:0] index;
      logic [19:0]       pfn;
      logic [2:0]        c;
      logic              d;
      logic              v;
   } resp_t;

   typedef enum logic {
      IDLE = 1'b0,
      WALK = 1'b1
   } walk_state_t;

   tlb_entry_t        ent_q [TLBNUM];
   logic [TLBNUM-1:0] v0_q;
   logic [TLBNUM-1:0] v1_q;

   walk_state_t       state_q, state_d;
   logic [IDX_WD-1:0] cnt_q, cnt_d;
   logic              clr_en;

   logic [TLBNUM-1:0] hit_vec;
   logic              hit_found;
   logic [IDX_WD-1:0] hit_idx;
   tlb_entry_t        hit_ent;
   resp_t             hit_resp;

   logic              resp_vld_q;
   resp_t             resp_q;
   logic              req_acc;
   tlb_entry_t        w_ent;

   // ---------------- entry array ----------------
   assign w_ent = '{vpn2: w_vpn2, asid: w_asid, g: w_g,
                    p0: '{pfn: w_pfn0, c: w_c0, d: w_d0},
                    p1: '{pfn: w_pfn1, c: w_c1, d: w_d1}};

   // Only the valid bits need reset; the remaining fields are qualified by them.
   always_ff @(posedge clk) begin
      if (we) begin
         ent_q[w_index] <= w_ent;
      end
   end

   // A walker clear on the same entry as a write lands after it, so the clear wins.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         v0_q <= '0;
         v1_q <= '0;
      end else begin
         if (we) begin
            v0_q[w_index] <= w_v0;
            v1_q[w_index] <= w_v1;
         end
         if (clr_en) begin
            v0_q[cnt_q] <= 1'b0;
            v1_q[cnt_q] <= 1'b0;
         end
      end
   end

   // ---------------- invalidate-all walker ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (inv_all) begin
               state_d = WALK;
               cnt_d   = '0;
            end
         end
         WALK: begin
            clr_en = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == IDX_WD'(TLBNUM - 1)) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy = (state_q == WALK);

   // ---------------- search ----------------
   always_comb begin
      for (int i = 0; i < TLBNUM; i++) begin
         hit_vec[i] = (ent_q[i].vpn2 == s_vpn2) && (ent_q[i].g || (ent_q[i].asid == s_asid));
      end
   end

   // Descending scan so the lowest hitting index is the last one written.
   always_comb begin
      hit_found = 1'b0;
      hit_idx   = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
         if (hit_vec[i]) begin
            hit_found = 1'b1;
            hit_idx   = IDX_WD'(i);
         end
      end
   end

   assign hit_ent = ent_q[hit_idx];

   always_comb begin
      hit_resp = '0;
      if (hit_found) begin
         hit_resp.found = 1'b1;
         hit_resp.index = hit_idx;
         if (s_odd_page) begin
            hit_resp.pfn = hit_ent.p1.pfn;
            hit_resp.c   = hit_ent.p1.c;
            hit_resp.d   = hit_ent.p1.d;
            hit_resp.v   = v1_q[hit_idx];
         end else begin
            hit_resp.pfn = hit_ent.p0.pfn;
            hit_resp.c   = hit_ent.p0.c;
            hit_resp.d   = hit_ent.p0.d;
            hit_resp.v   = v0_q[hit_idx];
         end
      end
   end

   // ---------------- response register ----------------
   assign s_req_ready = !busy && (!resp_vld_q || s_resp_ready);
   assign req_acc     = s_req_valid && s_req_ready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         resp_vld_q <= 1'b0;
         resp_q     <= '0;
      end else if (req_acc) begin
         resp_vld_q <= 1'b1;
         resp_q     <= hit_resp;
      end else if (s_resp_ready) begin
         resp_vld_q <= 1'b0;
      end
   end

   assign s_resp_valid = resp_vld_q;
   assign s_found      = resp_q.found;
   assign s_index      = resp_q.index;
   assign s_pfn        = resp_q.pfn;
   assign s_c          = resp_q.c;
   assign s_d          = resp_q.d;
   assign s_v          = resp_q.v;

endmodule
